// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder and the palindrome detector it drives:
// FSM state encodings and a counter-width helper that never returns zero.
package serial_word_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // $clog2 with a floor of 1 so a counter for a single-element range still has a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_feeder_piso.sv
// Parallel-in serial-out register: loads a word, then presents one bit per shift enable
// at head, MSB or LSB first. Vacated positions fill with zero.
module piso_shift_reg #(
  parameter int BITS      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift_en,
  input  logic [BITS-1:0] data,
  output logic            head
);

  logic [BITS-1:0] shreg;
  logic [BITS-1:0] shifted;

  generate
    if (BITS == 1) begin : g_single
      assign shifted = 1'b0;
      assign head    = shreg[0];
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg[BITS-2:0], 1'b0};
      assign head    = shreg[BITS-1];
    end else begin : g_lsb
      assign shifted = {1'b0, shreg[BITS-1:1]};
      assign head    = shreg[0];
    end
  endgenerate

  // Load wins over shift so a word accepted on the last-bit edge replaces the old one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift_en) begin
      shreg <= shifted;
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Serialiser in front of palindrome_detector: takes parallel words on a valid/ready input and
// emits them one bit per cycle, with optional idle gap between words and downstream stall.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int BITS      = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_bit,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  input  logic            out_ready,
  output state_t          dbg_state
);

  // Handshakes: a word transfers on a posedge where in_valid && in_ready; a serial bit is
  // consumed on a posedge where out_valid && out_ready, and out_* hold unchanged until then.

  localparam int CW = clog2_min1(BITS);
  localparam int GW = clog2_min1((GAP > 0) ? GAP : 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BITS - 1);
  localparam logic [GW-1:0] GAP_END  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic SINGLE_BIT = (BITS == 1);
  localparam logic NO_GAP     = (GAP == 0);

  state_t          state;
  logic [CW-1:0]   bitcnt;
  logic [CW-1:0]   bitcnt_nxt;
  logic [GW-1:0]   gapcnt;
  logic            valid_q;
  logic            first_q;
  logic            last_q;
  logic            advance;
  logic            word_end;
  logic            accept;
  logic            head;

  assign bitcnt_nxt = bitcnt + CW'(1);
  assign advance    = (state == ST_SHIFT) && out_ready;
  assign word_end   = advance && last_q;
  // Ready on the last-bit edge only when no gap follows, so words stream without a bubble.
  assign in_ready   = (state == ST_IDLE) || (word_end && NO_GAP);
  assign accept     = in_valid && in_ready;

  piso_shift_reg #(
    .BITS      (BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (advance),
    .data     (in_data),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bitcnt  <= '0;
      gapcnt  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SHIFT;
            bitcnt  <= '0;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= SINGLE_BIT;
          end
        end
        ST_SHIFT: begin
          if (advance) begin
            if (last_q) begin
              if (accept) begin
                state   <= ST_SHIFT;
                bitcnt  <= '0;
                valid_q <= 1'b1;
                first_q <= 1'b1;
                last_q  <= SINGLE_BIT;
              end else begin
                state   <= NO_GAP ? ST_IDLE : ST_GAP;
                gapcnt  <= '0;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              bitcnt  <= bitcnt_nxt;
              first_q <= 1'b0;
              last_q  <= (bitcnt_nxt == LAST_IDX);
            end
          end
        end
        ST_GAP: begin
          if (gapcnt == GAP_END) begin
            state <= ST_IDLE;
          end else begin
            gapcnt <= gapcnt + GW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // The shifter zero-fills, but gating keeps out_bit at 0 whenever no word bit is presented.
  assign out_bit   = valid_q & head;
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: three configurations (4-bit MSB-first, 4-bit with gap of 2,
// 1-bit LSB-first) checked against expected-bit queues plus cycle-level handshake checks.
module tb_serial_word_feeder;
  import serial_word_feeder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT a: BITS=4, MSB_FIRST=1, GAP=0 ----------------
  logic [3:0] a_in_data = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready, a_out_bit, a_out_valid, a_out_first, a_out_last;
  logic       a_out_ready;
  logic       man_ready = 1'b1;
  logic       rnd_ready = 1'b1;
  logic       rand_mode = 1'b0;
  state_t     a_state;
  assign a_out_ready = rand_mode ? rnd_ready : man_ready;

  serial_word_feeder #(.BITS(4), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_bit(a_out_bit), .out_valid(a_out_valid),
    .out_first(a_out_first), .out_last(a_out_last), .out_ready(a_out_ready),
    .dbg_state(a_state)
  );

  // ---------------- DUT g: BITS=4, MSB_FIRST=1, GAP=2 ----------------
  logic [3:0] g_in_data = '0;
  logic       g_in_valid = 1'b0;
  logic       g_in_ready, g_out_bit, g_out_valid, g_out_first, g_out_last;
  logic       g_out_ready = 1'b1;
  state_t     g_state;

  serial_word_feeder #(.BITS(4), .MSB_FIRST(1'b1), .GAP(2)) dut_g (
    .clk(clk), .reset(reset), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .out_bit(g_out_bit), .out_valid(g_out_valid),
    .out_first(g_out_first), .out_last(g_out_last), .out_ready(g_out_ready),
    .dbg_state(g_state)
  );

  // ---------------- DUT s: BITS=1, MSB_FIRST=0, GAP=0 ----------------
  logic [0:0] s_in_data = '0;
  logic       s_in_valid = 1'b0;
  logic       s_in_ready, s_out_bit, s_out_valid, s_out_first, s_out_last;
  logic       s_out_ready = 1'b1;
  state_t     s_state;

  serial_word_feeder #(.BITS(1), .MSB_FIRST(1'b0), .GAP(0)) dut_s (
    .clk(clk), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_bit(s_out_bit), .out_valid(s_out_valid),
    .out_first(s_out_first), .out_last(s_out_last), .out_ready(s_out_ready),
    .dbg_state(s_state)
  );

  // ---------------- scoreboard: {first, last, bit} per expected serial bit ----------------
  logic [2:0] exp_a[$];
  logic [2:0] exp_g[$];
  logic [2:0] exp_s[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push4(input logic [3:0] w, input bit to_g);
    logic [2:0] e;
    for (int i = 0; i < 4; i++) begin
      e = {(i == 0), (i == 3), w[3-i]};
      if (to_g) exp_g.push_back(e);
      else exp_a.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) check("a_extra_bit", 1, 0);
        else check("a_bit", {a_out_first, a_out_last, a_out_bit}, exp_a.pop_front());
      end
      if (!a_out_valid) check("a_idle_out", {a_out_first, a_out_last, a_out_bit}, 0);
      if (g_out_valid && g_out_ready) begin
        if (exp_g.size() == 0) check("g_extra_bit", 1, 0);
        else check("g_bit", {g_out_first, g_out_last, g_out_bit}, exp_g.pop_front());
      end
      if (!g_out_valid) check("g_idle_out", {g_out_first, g_out_last, g_out_bit}, 0);
      if (s_out_valid && s_out_ready) begin
        if (exp_s.size() == 0) check("s_extra_bit", 1, 0);
        else check("s_bit", {s_out_first, s_out_last, s_out_bit}, exp_s.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] w);
    bit got = 1'b0;
    a_in_data  = w;
    a_in_valid = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (a_in_ready) got = 1'b1;
      step();
    end
    a_in_valid = 1'b0;
    if (got) push4(w, 1'b0);
    else check("a_send_timeout", 0, 1);
  endtask

  task automatic drain_all();
    int n = 0;
    while ((exp_a.size() + exp_g.size() + exp_s.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("a_drain", exp_a.size(), 0);
    check("g_drain", exp_g.size(), 0);
    check("s_drain", exp_s.size(), 0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    check("a_rst_out", {a_out_valid, a_out_bit, a_out_first, a_out_last, a_in_ready}, 5'b00001);
    check("g_rst_out", {g_out_valid, g_out_bit, g_out_first, g_out_last, g_in_ready}, 5'b00001);
    check("s_rst_out", {s_out_valid, s_out_bit, s_out_first, s_out_last, s_in_ready}, 5'b00001);
    check("a_rst_state", a_state, ST_IDLE);
    step();

    // 1: single word 1001
    a_in_data = 4'b1001;
    a_in_valid = 1'b1;
    @(negedge clk);
    check("t1_ready_idle", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    a_in_data = 4'b0110;
    push4(4'b1001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", a_out_valid, 1);
      check("t1_ready", a_in_ready, (i == 3));
      step();
    end
    @(negedge clk);
    check("t1_after_valid", a_out_valid, 0);
    drain_all();

    // 2: back-to-back 1011 then 0110 with in_valid held
    a_in_data = 4'b1011;
    a_in_valid = 1'b1;
    @(negedge clk);
    check("t2_ready_idle", a_in_ready, 1);
    step();
    a_in_data = 4'b0110;
    push4(4'b1011, 1'b0);
    push4(4'b0110, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_valid", a_out_valid, 1);
      check("t2_ready", a_in_ready, (i % 4 == 3));
      step();
      if (i == 3) a_in_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_after_valid", a_out_valid, 0);
    check("t2_after_ready", a_in_ready, 1);
    drain_all();

    // 3: GAP=2 configuration, word 1100
    g_in_data = 4'b1100;
    g_in_valid = 1'b1;
    @(negedge clk);
    check("t3_ready_idle", g_in_ready, 1);
    step();
    g_in_valid = 1'b0;
    push4(4'b1100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_valid", g_out_valid, (i < 4));
      check("t3_ready", g_in_ready, 0);
      if (i >= 4) check("t3_gap_bit", g_out_bit, 0);
      step();
    end
    @(negedge clk);
    check("t3_ready_after_gap", g_in_ready, 1);
    check("t3_state_idle", g_state, ST_IDLE);
    drain_all();

    // 4: stall on the third bit of 1010
    a_in_data = 4'b1010;
    a_in_valid = 1'b1;
    @(negedge clk);
    step();
    a_in_valid = 1'b0;
    push4(4'b1010, 1'b0);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold", {a_out_valid, a_out_bit, a_out_first, a_out_last}, 4'b1100);
      check("t4_hold_ready", a_in_ready, 0);
      step();
    end
    man_ready = 1'b1;
    drain_all();

    // 5: reset during bit 2 of 1111, then 0001 emitted intact
    a_in_data = 4'b1111;
    a_in_valid = 1'b1;
    @(negedge clk);
    step();
    a_in_valid = 1'b0;
    push4(4'b1111, 1'b0);
    @(negedge clk);
    step();
    reset = 1'b0;
    step();
    exp_a.delete();
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", a_out_valid, 0);
    check("t5_rst_ready", a_in_ready, 1);
    check("t5_rst_bit", a_out_bit, 0);
    step();
    send_a(4'b0001);
    drain_all();

    // 6: BITS=1, LSB first, single bit 1
    s_in_data = 1'b1;
    s_in_valid = 1'b1;
    @(negedge clk);
    check("t6_ready_idle", s_in_ready, 1);
    step();
    s_in_valid = 1'b0;
    s_in_data = 1'b0;
    exp_s.push_back(3'b111);
    @(negedge clk);
    check("t6_out", {s_out_valid, s_out_bit, s_out_first, s_out_last}, 4'b1111);
    check("t6_ready_last", s_in_ready, 1);
    step();
    @(negedge clk);
    check("t6_after_valid", s_out_valid, 0);
    drain_all();

    // random words with random downstream stall; in_data scrambled between words
    rand_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send_a(4'($urandom_range(0, 15)));
      a_in_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) step();
    end
    drain_all();
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
